// File: rtl/syn_fifo_responder.sv
// syn_fifo_responder: single-clock FIFO answering the CPU FIFO bus, with status flags
// and an almost-full/almost-empty offset loaded through daf_i while the FIFO is empty.
module syn_fifo_responder #(
  parameter int FIFO_ENTRIES  = 1024,
  parameter int DATA_WIDTH    = 16,
  parameter int AF_AE_DEFAULT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic                  daf_i,
  input  logic                  oe_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic                  fifo_empty_o,
  output logic                  fifo_full_o,
  output logic                  half_full_o,
  output logic                  af_ae_o,
  output logic [DATA_WIDTH-1:0] data_out_o
);
  localparam int AW = $clog2(FIFO_ENTRIES);
  logic [DATA_WIDTH-1:0] mem [FIFO_ENTRIES];
  logic [AW-1:0] w_pointer, r_pointer, offset, daf_val, daf_clamped;
  logic [AW:0] count, count_nxt;
  logic [DATA_WIDTH-1:0] rdata;
  logic wr_ok, rd_ok, daf_ok;
  assign wr_ok = wr_i & ~fifo_full_o;
  assign rd_ok = rd_i & ~fifo_empty_o;
  assign daf_ok = daf_i & fifo_empty_o & ~wr_i;
  assign daf_val = data_in_i[AW-1:0];
  // Out-of-range offsets would make af_ae meaningless, so fall back to the default.
  assign daf_clamped = (daf_val == '0 || daf_val >= AW'(FIFO_ENTRIES/2)) ? AW'(AF_AE_DEFAULT) : daf_val;
  always_comb begin
    count_nxt = (wr_ok && !rd_ok) ? count + (AW+1)'(1) :
                (rd_ok && !wr_ok) ? count - (AW+1)'(1) : count;
  end
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[w_pointer] <= data_in_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_pointer <= '0;
      r_pointer <= '0;
      count     <= '0;
      rdata     <= '0;
      offset    <= AW'(AF_AE_DEFAULT);
    end else begin
      count <= count_nxt;
      if (wr_ok) w_pointer <= w_pointer + AW'(1);
      if (rd_ok) begin
        r_pointer <= r_pointer + AW'(1);
        rdata     <= mem[r_pointer];
      end
      if (daf_ok) offset <= daf_clamped;
    end
  end
  assign fifo_empty_o = count == '0;
  assign fifo_full_o  = count == (AW+1)'(FIFO_ENTRIES);
  assign half_full_o  = count >= (AW+1)'(FIFO_ENTRIES/2);
  assign af_ae_o      = count <= {1'b0, offset} || count >= (AW+1)'(FIFO_ENTRIES) - {1'b0, offset};
  assign data_out_o   = oe_i ? rdata : '0;
endmodule

// File: tb/tb_syn_fifo_responder.sv
// tb_syn_fifo_responder: directed scenario tasks with hand-computed expectations.
module tb_syn_fifo_responder;
  logic clk_i = 0, rst_i = 0, wr_i = 0, rd_i = 0, daf_i = 0, oe_i = 1;
  logic [15:0] data_in_i = '0;
  logic fifo_empty_o, fifo_full_o, half_full_o, af_ae_o;
  logic [15:0] data_out_o;
  int passed = 0, total = 0;
  syn_fifo_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_i(wr_i), .rd_i(rd_i), .daf_i(daf_i), .oe_i(oe_i),
    .data_in_i(data_in_i), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
    .half_full_o(half_full_o), .af_ae_o(af_ae_o), .data_out_o(data_out_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic cyc(input logic w, input logic r, input logic d, input logic [15:0] din);
    wr_i = w; rd_i = r; daf_i = d; data_in_i = din;
    @(posedge clk_i); #1;
    wr_i = 0; rd_i = 0; daf_i = 0;
  endtask
  task automatic fill(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, base + 16'(i));
  endtask
  task automatic do_reset;
    @(negedge clk_i); rst_i = 1;
    @(negedge clk_i); rst_i = 0;
    @(posedge clk_i); #1;
  endtask
  task automatic test_reset;
    do_reset();
    fill(5, 16'h0100);
    cyc(0, 1, 0, 0);
    wr_i = 1; data_in_i = 16'h0777;
    #3 rst_i = 1;
    #1;
    total++; if (fifo_empty_o !== 1'b1) $display("FAIL rst_async_empty: got %b want 1", fifo_empty_o); else passed++;
    wr_i = 0;
    #149 rst_i = 0;
    @(posedge clk_i); #1;
    total++; if (fifo_empty_o !== 1'b1) $display("FAIL rst_empty: got %b want 1", fifo_empty_o); else passed++;
    total++; if (fifo_full_o !== 1'b0) $display("FAIL rst_full: got %b want 0", fifo_full_o); else passed++;
    total++; if (half_full_o !== 1'b0) $display("FAIL rst_half: got %b want 0", half_full_o); else passed++;
    total++; if (af_ae_o !== 1'b1) $display("FAIL rst_af_ae: got %b want 1", af_ae_o); else passed++;
    total++; if (data_out_o !== 16'h0000) $display("FAIL rst_data_out: got %h want 0000", data_out_o); else passed++;
    total++; if (dut.w_pointer !== 10'd0) $display("FAIL rst_w_pointer: got %0d want 0", dut.w_pointer); else passed++;
    total++; if (dut.r_pointer !== 10'd0) $display("FAIL rst_r_pointer: got %0d want 0", dut.r_pointer); else passed++;
  endtask
  task automatic test_ordered;
    int errs;
    do_reset();
    fill(16, 16'h0001);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0);
      if (data_out_o !== 16'(i + 1)) begin
        if (errs == 0) $display("FAIL ordered_word%0d: got %h want %h", i, data_out_o, 16'(i + 1));
        errs++;
      end
    end
    total++; if (errs != 0) $display("FAIL ordered_errors: got %0d want 0", errs); else passed++;
    total++; if (fifo_empty_o !== 1'b1) $display("FAIL ordered_empty: got %b want 1", fifo_empty_o); else passed++;
  endtask
  task automatic test_fill_overflow;
    int errs;
    do_reset();
    fill(1024, 16'h8000);
    total++; if (fifo_full_o !== 1'b1) $display("FAIL fill_full: got %b want 1", fifo_full_o); else passed++;
    total++; if (dut.w_pointer !== 10'd0) $display("FAIL fill_w_wrap: got %0d want 0", dut.w_pointer); else passed++;
    cyc(1, 0, 0, 16'hBEEF);
    total++; if (dut.w_pointer !== 10'd0) $display("FAIL overflow_w_pointer: got %0d want 0", dut.w_pointer); else passed++;
    total++; if (fifo_full_o !== 1'b1) $display("FAIL overflow_full: got %b want 1", fifo_full_o); else passed++;
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      cyc(0, 1, 0, 0);
      if (data_out_o !== 16'h8000 + 16'(i)) begin
        if (errs == 0) $display("FAIL fill_word%0d: got %h want %h", i, data_out_o, 16'h8000 + 16'(i));
        errs++;
      end
    end
    total++; if (errs != 0) $display("FAIL fill_errors: got %0d want 0", errs); else passed++;
    total++; if (data_out_o !== 16'h83FF) $display("FAIL fill_last: got %h want 83ff", data_out_o); else passed++;
    total++; if (fifo_empty_o !== 1'b1) $display("FAIL fill_drained: got %b want 1", fifo_empty_o); else passed++;
    cyc(0, 1, 0, 0);
    total++; if (dut.r_pointer !== 10'd0 || data_out_o !== 16'h83FF) $display("FAIL underflow: got rp=%0d data=%h want rp=0 data=83ff", dut.r_pointer, data_out_o); else passed++;
  endtask
  task automatic test_flags;
    do_reset();
    fill(8, 0);
    total++; if (af_ae_o !== 1'b1) $display("FAIL flags_c8_af_ae: got %b want 1", af_ae_o); else passed++;
    fill(1, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL flags_c9_af_ae: got %b want 0", af_ae_o); else passed++;
    fill(502, 0);
    total++; if (half_full_o !== 1'b0) $display("FAIL flags_c511_half: got %b want 0", half_full_o); else passed++;
    fill(1, 0);
    total++; if (half_full_o !== 1'b1) $display("FAIL flags_c512_half: got %b want 1", half_full_o); else passed++;
    fill(503, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL flags_c1015_af_ae: got %b want 0", af_ae_o); else passed++;
    fill(1, 0);
    total++; if (af_ae_o !== 1'b1 || fifo_full_o !== 1'b0) $display("FAIL flags_c1016: got af_ae=%b full=%b want 1 0", af_ae_o, fifo_full_o); else passed++;
    cyc(0, 1, 0, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL flags_c1015_down: got %b want 0", af_ae_o); else passed++;
  endtask
  task automatic test_daf;
    do_reset();
    cyc(0, 0, 1, 16'h0040);
    fill(64, 0);
    total++; if (af_ae_o !== 1'b1) $display("FAIL daf64_c64: got %b want 1", af_ae_o); else passed++;
    fill(1, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL daf64_c65: got %b want 0", af_ae_o); else passed++;
    fill(894, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL daf64_c959: got %b want 0", af_ae_o); else passed++;
    fill(1, 0);
    total++; if (af_ae_o !== 1'b1) $display("FAIL daf64_c960: got %b want 1", af_ae_o); else passed++;
    do_reset();
    fill(3, 0);
    cyc(0, 0, 1, 16'h0040);
    fill(6, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL daf_nonempty_c9: got %b want 0", af_ae_o); else passed++;
    do_reset();
    cyc(0, 0, 1, 16'h0300);
    fill(8, 0);
    total++; if (af_ae_o !== 1'b1) $display("FAIL daf_clamp_c8: got %b want 1", af_ae_o); else passed++;
    fill(1, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL daf_clamp_c9: got %b want 0", af_ae_o); else passed++;
    do_reset();
    cyc(1, 0, 1, 16'h0040);
    fill(8, 0);
    total++; if (af_ae_o !== 1'b0) $display("FAIL daf_with_wr_c9: got %b want 0", af_ae_o); else passed++;
  endtask
  task automatic test_simultaneous;
    do_reset();
    fill(5, 16'h00A0);
    cyc(1, 1, 0, 16'h00A5);
    total++; if (dut.count !== 11'd5) $display("FAIL rdwr_c5_count: got %0d want 5", dut.count); else passed++;
    total++; if (data_out_o !== 16'h00A0) $display("FAIL rdwr_c5_data: got %h want 00a0", data_out_o); else passed++;
    do_reset();
    fill(1, 16'h1234);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 16'h5678);
    total++; if (dut.count !== 11'd1 || fifo_empty_o !== 1'b0) $display("FAIL rdwr_empty_count: got %0d empty=%b want 1 0", dut.count, fifo_empty_o); else passed++;
    total++; if (data_out_o !== 16'h1234) $display("FAIL rdwr_empty_rdata: got %h want 1234", data_out_o); else passed++;
    cyc(0, 1, 0, 0);
    total++; if (data_out_o !== 16'h5678) $display("FAIL rdwr_empty_stored: got %h want 5678", data_out_o); else passed++;
    do_reset();
    fill(1024, 16'h4000);
    cyc(1, 1, 0, 16'hFFFF);
    total++; if (dut.count !== 11'd1023 || fifo_full_o !== 1'b0) $display("FAIL rdwr_full_count: got %0d full=%b want 1023 0", dut.count, fifo_full_o); else passed++;
    total++; if (data_out_o !== 16'h4000) $display("FAIL rdwr_full_data: got %h want 4000", data_out_o); else passed++;
    oe_i = 0;
    cyc(0, 1, 0, 0);
    total++; if (data_out_o !== 16'h0000) $display("FAIL oe0_data_out: got %h want 0000", data_out_o); else passed++;
    total++; if (dut.count !== 11'd1022) $display("FAIL oe0_consumed: got %0d want 1022", dut.count); else passed++;
    oe_i = 1;
    #1;
    total++; if (data_out_o !== 16'h4001) $display("FAIL oe1_restore: got %h want 4001", data_out_o); else passed++;
  endtask
  initial begin
    test_reset();
    test_ordered();
    test_fill_overflow();
    test_flags();
    test_daf();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
